// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel-clock divider and registered outputs.
// Define VGA_PIXEL_ADDR_EN to add the linear framebuffer address output pix_addr.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int HSYNC_NEG = 1,
  parameter int VSYNC_NEG = 1,
  parameter int CLK_DIV = 2,
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int COL_W = $clog2(H_TOTAL),
  localparam int ROW_W = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_tick,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             visible,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
`ifdef VGA_PIXEL_ADDR_EN
  output logic [$clog2(H_VISIBLE*V_VISIBLE)-1:0] pix_addr,
`endif
  output logic             frame_start
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COL_W-1:0] H_LAST = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0] H_VIS = COL_W'(H_VISIBLE);
  localparam logic [COL_W-1:0] HS_BEG = COL_W'(H_VISIBLE + H_FP);
  localparam logic [COL_W-1:0] HS_END = COL_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [ROW_W-1:0] V_LAST = ROW_W'(V_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_VIS = ROW_W'(V_VISIBLE);
  localparam logic [ROW_W-1:0] VS_BEG = ROW_W'(V_VISIBLE + V_FP);
  localparam logic [ROW_W-1:0] VS_END = ROW_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic HS_OFF = HSYNC_NEG != 0;
  localparam logic VS_OFF = VSYNC_NEG != 0;
  generate
    if (CLK_DIV < 1 || H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
      $error("vga_timing_gen: CLK_DIV and all visible/porch/sync values must be >= 1");
    end
  endgenerate
  logic [DIV_W-1:0] div;
  logic adv, h_end, vis_n;
  logic [COL_W-1:0] col_n;
  logic [ROW_W-1:0] row_n;
  // Outputs are loaded from the next position so they change only on the advance edge.
  always_comb begin
    adv = en && div == DIV_LAST;
    h_end = col == H_LAST;
    col_n = h_end ? '0 : col + 1'b1;
    row_n = h_end ? (row == V_LAST ? '0 : row + 1'b1) : row;
    vis_n = col_n < H_VIS && row_n < V_VIS;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      col <= H_LAST;
      row <= V_LAST;
      pix_tick <= 1'b0;
      visible <= 1'b0;
      hsync <= HS_OFF;
      vsync <= VS_OFF;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      div <= adv ? '0 : div + 1'b1;
      pix_tick <= adv;
      if (adv) begin
        col <= col_n;
        row <= row_n;
        visible <= vis_n;
        hsync <= (col_n >= HS_BEG && col_n < HS_END) ^ HS_OFF;
        vsync <= (row_n >= VS_BEG && row_n < VS_END) ^ VS_OFF;
        line_start <= col_n == '0;
        frame_start <= col_n == '0 && row_n == '0;
      end
    end
  end
`ifdef VGA_PIXEL_ADDR_EN
  // Address advances only into visible pixels, so blanking holds the last visible address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_addr <= '0;
    else if (adv) pix_addr <= (col_n == '0 && row_n == '0) ? '0 : vis_n ? pix_addr + 1'b1 : pix_addr;
  end
`endif
endmodule
